spi_regfile_arbiter: RTL and testbench
======================================

// Module: spi_regfile_arbiter
// PURPOSE
// - Owns the device register file and shares it between NREQ SPI front-ends (own-clock slave after CDC, sampled slave).
// - Round-robin arbitration with a 4-phase req/ack handshake per requester.
// - Only one access at a time, so concurrent writes are never dropped or silently prioritised.
// - Exposes all registers in parallel for downstream consumers (PWM config).
// PARAMETERS
// - NREQ      2            number of requesters
// - ADDR_W    2            register address width; NREGS = 2**ADDR_W (localparam)
// - DATA_W    8            register width
// - RST_VALS  32'h03020196 concatenated reset values, reg0 in LSBs (reg0=0x96 ID)
// - RO_MASK   4'b0001      bit i set -> reg i read-only
// PORTS
// - clk       in   1               system clock; single clock domain
// - rst       in   1               asynchronous, active-high reset
// - req       in   NREQ            access request, per requester
// - we        in   NREQ            1=write, 0=read; valid while req high
// - addr      in   NREQ*ADDR_W     register address, requester i at [i*ADDR_W +: ADDR_W]
// - wdata     in   NREQ*DATA_W     write data, requester i at [i*DATA_W +: DATA_W]
// - ack       out  NREQ            one-hot; high to granted requester until its req drops
// - rdata     out  DATA_W          read data (old value on write); valid while any ack high
// - err       out  1               high with ack when write hit an RO register
// - busy      out  1               high in every state except IDLE
// - regs_flat out  NREGS*DATA_W    all registers, reg i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
// - Reset: state=IDLE, ack=0, rdata=0, err=0, busy=0, regs=RST_VALS, rr pointer=NREQ-1 (requester 0 wins first tie).
// - FSM, all outputs registered:
//   - IDLE: any req -> GRANT. Winner = first requester after rr pointer (wrapping). Capture winner's we/addr/wdata; set pointer=winner.
//   - GRANT (1 cycle): rdata <= reg[addr].
//     - Write && !RO_MASK[addr]: reg[addr] <= wdata.
//     - Write && RO: reg unchanged, err <= 1.
//     - -> ACK.
//   - ACK: ack[winner]=1. Stay while req[winner]=1. On req[winner]=0: ack<=0, err<=0 -> IDLE.
// - Latency: req rises cycle 0 (IDLE) -> reg updated end of cycle 1 -> ack high cycle 2. Min transaction 4 cycles incl. drop.
// - Inputs sampled only on the IDLE->GRANT edge; later changes to addr/wdata/we are ignored.
// - Requester drops req before ack (abort):
//   - Access still commits.
//   - ACK sees req low -> ack pulses exactly 1 cycle -> IDLE.
// - Simultaneous reqs: one grant per transaction. Loser's req stays pending and is served in the next IDLE, so no starvation.
// - Same requester re-requests immediately: it wins only if no other req is pending.
// - req[winner] high, others toggling during ACK: no effect.
// - Address wrap: ADDR_W bits cover all NREGS; no out-of-range case.
// - regs_flat updates the cycle after GRANT, same cycle ack rises.
// - Reset mid-transaction: immediate return to reset state. Partial write is either fully committed (GRANT edge passed) or absent.
// STRUCTURE
// - Shared package spi_regs_pkg: ADDR_W, DATA_W, RST_VALS, RO_MASK defaults, state encoding (IDLE/GRANT/ACK).
// - Sub-module rr_arbiter #(NREQ): comb winner one-hot + index from req and pointer. Pointer register stays in this block.
// - Register file and FSM live in this block; no memory macro.
// TESTING
// - Reset only -> regs_flat=0x03020196, ack=0, busy=0, err=0.
// - Req0 write addr2 data 0xA5, hold until ack, then drop:
//   - ack[0] high 2 cycles after req.
//   - reg2=0xA5; rdata=0x02 (old value).
// - Req0 and req1 rise same cycle, both read addr0:
//   - ack[0] first; rdata=0x96.
//   - After drop, ack[1]; next tie goes to req0 again only after req1 served.
// - Req1 write addr0 data 0x55 -> err=1 with ack[1], reg0 stays 0x96.
// - Req0 pulses 1 cycle with write addr3 data 0x7E -> ack[0] 1-cycle pulse, reg3=0x7E, FSM back to IDLE.
// - rst asserted in GRANT of write addr1 data 0xFF -> all outputs reset immediately; reg1=0x01 after release.

Source files
------------

// File: rtl/spi_regfile_arbiter_pkg.sv
// Shared constants and FSM state encoding for the SPI register file arbiter.
// Provides default geometry, reset values, read-only mask and states.
package spi_regs_pkg;
  localparam int SPI_NREQ = 2;
  localparam int SPI_ADDR_W = 2;
  localparam int SPI_DATA_W = 8;
  localparam logic [31:0] SPI_RST_VALS = 32'h0302_0196;
  localparam logic [3:0] SPI_RO_MASK = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;
endpackage

// File: rtl/spi_regfile_arbiter_if.sv
// Requester-side bus of the register file arbiter.
// master: req/we/addr/wdata out, ack/rdata/err/busy in; slave: reverse.
interface spi_regfile_arbiter_if #(
  parameter int NREQ = 2,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   err;
  logic                   busy;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err, busy
  );
endinterface

// File: rtl/spi_regfile_arbiter_rr.sv
// Round-robin arbiter: combinational winner from req and pointer.
// Ports: clk, rst, req, load (commit winner to pointer), gnt_oh, gnt_idx.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             load,
  output logic [NREQ-1:0]  gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;

  // Search starts one past the last winner and wraps.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[IDX_W'((int'(ptr_q) + k) % NREQ)]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'((int'(ptr_q) + k) % NREQ);
        gnt_oh[IDX_W'((int'(ptr_q) + k) % NREQ)] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load && found)
      ptr_d = gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IDX_W'(NREQ - 1);
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/spi_regfile_arbiter.sv
// Register file shared by NREQ requesters through a req/ack FSM.
// Ports: clk, rst, bus (slave side of the requester bus), regs_flat.
module spi_regfile_arbiter
  import spi_regs_pkg::*;
#(
  parameter int NREQ = SPI_NREQ,
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int DATA_W = SPI_DATA_W,
  parameter logic [(2**ADDR_W)*DATA_W-1:0] RST_VALS = SPI_RST_VALS,
  parameter logic [(2**ADDR_W)-1:0] RO_MASK = SPI_RO_MASK
) (
  input  logic clk,
  input  logic rst,
  spi_regfile_arbiter_if.slave bus,
  output logic [(2**ADDR_W)*DATA_W-1:0] regs_flat
);
  localparam int NREGS = 2**ADDR_W;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   win_q, win_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [NREQ-1:0]  arb_oh;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_load;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req),
    .load   (arb_load),
    .gnt_oh (arb_oh),
    .gnt_idx(arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    win_d    = win_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    regs_d   = regs_q;
    arb_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          arb_load = 1'b1;
          win_d    = arb_oh;
          we_d     = bus.we[arb_idx];
          addr_d   = bus.addr[arb_idx*ADDR_W +: ADDR_W];
          wdata_d  = bus.wdata[arb_idx*DATA_W +: DATA_W];
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Read returns the pre-write value.
        rdata_d = regs_q[addr_q];
        if (we_q) begin
          if (RO_MASK[addr_q]) err_d = 1'b1;
          else                 regs_d[addr_q] = wdata_q;
        end
        ack_d   = win_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!(|(bus.req & win_q))) begin
          ack_d   = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      win_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= RST_VALS[i*DATA_W +: DATA_W];
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      win_q   <= win_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++)
      regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_spi_regfile_arbiter.sv
// Directed bench for spi_regfile_arbiter.
// Drives and samples on the falling edge; expectations hand-computed.
module tb_spi_regfile_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] regs_flat;
  int          n_cmp = 0;
  int          n_bad = 0;

  spi_regfile_arbiter_if #(.NREQ(2), .ADDR_W(2), .DATA_W(8)) bus ();

  spi_regfile_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int i, input logic r, input logic w,
                       input logic [1:0] a, input logic [7:0] d);
    bus.req[i]         = r;
    bus.we[i]          = w;
    bus.addr[i*2 +: 2] = a;
    bus.wdata[i*8 +: 8] = d;
  endtask

  initial begin
    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdata = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_regs", regs_flat, 32'h0302_0196);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_rdata", 32'(bus.rdata), 32'h0);

    // req0 writes 0xA5 to reg2; late wdata change must be ignored
    drive(0, 1'b1, 1'b1, 2'd2, 8'hA5);
    tick(1);
    chk("wr_busy_grant", 32'(bus.busy), 32'h1);
    chk("wr_ack_grant", 32'(bus.ack), 32'h0);
    drive(0, 1'b1, 1'b1, 2'd2, 8'h11);
    tick(1);
    chk("wr_ack", 32'(bus.ack), 32'h1);
    chk("wr_reg2", regs_flat, 32'h03A5_0196);
    chk("wr_rdata_old", 32'(bus.rdata), 32'h02);
    chk("wr_err", 32'(bus.err), 32'h0);
    tick(1);
    chk("wr_ack_hold", 32'(bus.ack), 32'h1);
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(1);
    chk("wr_ack_drop", 32'(bus.ack), 32'h0);
    chk("wr_busy_idle", 32'(bus.busy), 32'h0);

    // req1 writes read-only reg0
    drive(1, 1'b1, 1'b1, 2'd0, 8'h55);
    tick(2);
    chk("ro_ack", 32'(bus.ack), 32'h2);
    chk("ro_err", 32'(bus.err), 32'h1);
    chk("ro_reg0", regs_flat, 32'h03A5_0196);
    chk("ro_rdata", 32'(bus.rdata), 32'h96);
    drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(1);
    chk("ro_err_clr", 32'(bus.err), 32'h0);
    chk("ro_ack_clr", 32'(bus.ack), 32'h0);

    // tie, both read reg0: req0 first since req1 won last
    drive(0, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1, 1'b1, 1'b0, 2'd0, 8'h00);
    tick(2);
    chk("tie_ack0", 32'(bus.ack), 32'h1);
    chk("tie_rdata0", 32'(bus.rdata), 32'h96);
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(1);
    chk("tie_gap", 32'(bus.ack), 32'h0);
    tick(2);
    chk("tie_ack1", 32'(bus.ack), 32'h2);
    chk("tie_rdata1", 32'(bus.rdata), 32'h96);
    // other requester toggling during ACK has no effect
    drive(0, 1'b1, 1'b0, 2'd2, 8'h00);
    tick(1);
    drive(0, 1'b0, 1'b0, 2'd2, 8'h00);
    tick(1);
    chk("tie_hold1", 32'(bus.ack), 32'h2);
    drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(1);
    chk("tie_idle", 32'(bus.busy), 32'h0);

    // next tie after req1 served goes to req0 (read reg2)
    drive(0, 1'b1, 1'b0, 2'd2, 8'h00);
    drive(1, 1'b1, 1'b0, 2'd3, 8'h00);
    tick(2);
    chk("tie2_ack0", 32'(bus.ack), 32'h1);
    chk("tie2_rdata0", 32'(bus.rdata), 32'hA5);
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(3);
    chk("tie2_ack1", 32'(bus.ack), 32'h2);
    chk("tie2_rdata1", 32'(bus.rdata), 32'h03);
    drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(1);

    // abort: one-cycle req0 pulse writing 0x7E to reg3
    drive(0, 1'b1, 1'b1, 2'd3, 8'h7E);
    tick(1);
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(1);
    chk("abort_ack", 32'(bus.ack), 32'h1);
    chk("abort_reg3", regs_flat, 32'h7EA5_0196);
    tick(1);
    chk("abort_ack_off", 32'(bus.ack), 32'h0);
    chk("abort_idle", 32'(bus.busy), 32'h0);

    // reset while in GRANT of write reg1 0xFF
    drive(0, 1'b1, 1'b1, 2'd1, 8'hFF);
    tick(1);
    chk("rg_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rg_busy_rst", 32'(bus.busy), 32'h0);
    chk("rg_ack_rst", 32'(bus.ack), 32'h0);
    chk("rg_regs_rst", regs_flat, 32'h0302_0196);
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("rg_reg1", regs_flat, 32'h0302_0196);
    chk("rg_idle", 32'(bus.busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
